// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel edge detector.
//   LATENCY : clocks from an input pixel to its output pixel
//   GRAD_W  : signed width of Gx / Gy
//   MAG_W   : unsigned width of |Gx| + |Gy|
//   MAG_MAX : saturation ceiling of the output magnitude
//   ROW_W   : row counter width
package sobel_pkg;

  localparam int unsigned LATENCY = 4;
  localparam int unsigned GRAD_W  = 11;
  localparam int unsigned MAG_W   = 12;
  localparam int unsigned MAG_MAX = 255;
  localparam int unsigned ROW_W   = 12;

  typedef logic [7:0]               pix_t;
  typedef logic signed [GRAD_W-1:0] grad_t;

endpackage

// File: rtl/sobel_edge_detect_line_matrix.sv
// 3x3 window generator: two line buffers, nine tap registers, and the row/column counters.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_vsync       : frame sync (row counter clears on its rising edge)
//   i_href        : line valid, one pixel per clock while high
//   i_pix         : input pixel
//   o_p11..o_p33  : window taps; o_p33 = pixel (r,c), o_p22 = pixel (r-1,c-1)
//   o_tap_valid   : taps were updated by an accepted pixel on the previous clock
//   o_border      : window pixel lies in row < 2 or column < 2
module line_matrix_3x3
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_HDISP = 640
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vsync,
  input  logic i_href,
  input  pix_t i_pix,
  output pix_t o_p11,
  output pix_t o_p12,
  output pix_t o_p13,
  output pix_t o_p21,
  output pix_t o_p22,
  output pix_t o_p23,
  output pix_t o_p31,
  output pix_t o_p32,
  output pix_t o_p33,
  output logic o_tap_valid,
  output logic o_border
);

  localparam int unsigned COL_W  = $clog2(IMG_HDISP + 1);
  localparam int unsigned ADDR_W = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;

  logic             r_href_prev;
  logic             r_vs_prev;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  pix_t             r_lb1 [IMG_HDISP];  // row r-1
  pix_t             r_lb2 [IMG_HDISP];  // row r-2
  pix_t             r_p11, r_p12, r_p13, r_p21, r_p22, r_p23, r_p31, r_p32, r_p33;
  logic             r_tap_valid;
  logic             r_border;

  logic [ADDR_W-1:0] w_addr;
  pix_t              w_lb1;
  pix_t              w_lb2;
  logic              w_href_fall;
  logic              w_vs_rise;

  assign w_addr      = r_col[ADDR_W-1:0];
  assign w_lb1       = r_lb1[w_addr];
  assign w_lb2       = r_lb2[w_addr];
  assign w_href_fall = r_href_prev & ~i_href;
  assign w_vs_rise   = i_vsync & ~r_vs_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_href_prev <= 1'b0;
      r_vs_prev   <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
    end else begin
      r_href_prev <= i_href;
      r_vs_prev   <= i_vsync;
      // Frame start outranks a coincident end-of-line.
      if (w_vs_rise) begin
        r_row <= '0;
      end else if (w_href_fall && (r_row != '1)) begin
        r_row <= r_row + 1'b1;
      end
      if (i_href) begin
        r_col <= r_col + 1'b1;
      end else if (w_href_fall) begin
        r_col <= '0;
      end
    end
  end

  // The r-1 row moves into the r-2 buffer as the current row overwrites it.
  always_ff @(posedge clk) begin
    if (i_href) begin
      r_lb1[w_addr] <= i_pix;
      r_lb2[w_addr] <= w_lb1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p11 <= '0; r_p12 <= '0; r_p13 <= '0;
      r_p21 <= '0; r_p22 <= '0; r_p23 <= '0;
      r_p31 <= '0; r_p32 <= '0; r_p33 <= '0;
      r_tap_valid <= 1'b0;
      r_border    <= 1'b0;
    end else begin
      r_tap_valid <= i_href;
      r_border    <= (r_row < ROW_W'(2)) || (r_col < COL_W'(2));
      if (i_href) begin
        r_p11 <= r_p12; r_p12 <= r_p13; r_p13 <= w_lb2;
        r_p21 <= r_p22; r_p22 <= r_p23; r_p23 <= w_lb1;
        r_p31 <= r_p32; r_p32 <= r_p33; r_p33 <= i_pix;
      end
    end
  end

  assign o_p11 = r_p11;
  assign o_p12 = r_p12;
  assign o_p13 = r_p13;
  assign o_p21 = r_p21;
  assign o_p22 = r_p22;
  assign o_p23 = r_p23;
  assign o_p31 = r_p31;
  assign o_p32 = r_p32;
  assign o_p33 = r_p33;
  assign o_tap_valid = r_tap_valid;
  assign o_border    = r_border;

endmodule

// File: rtl/sobel_edge_detect.sv
// Streaming 3x3 Sobel edge detector with saturated magnitude and thresholded edge bit.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   per_frame_vsync   : input frame sync; threshold is latched on its rising edge
//   per_frame_href    : input line valid
//   per_img_y         : input grayscale pixel
//   threshold         : edge threshold
//   pos_frame_vsync   : vsync delayed by LATENCY
//   pos_frame_href    : href delayed by LATENCY
//   pos_img_y         : min(|Gx|+|Gy|, 255), 0 on borders and outside href
//   pos_img_bit       : pos_img_y > latched threshold
module sobel_edge_detect
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_HDISP = 640,
  parameter int unsigned DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic [DATA_W-1:0] per_img_y,
  input  logic [7:0]        threshold,
  output logic              pos_frame_vsync,
  output logic              pos_frame_href,
  output logic [7:0]        pos_img_y,
  output logic              pos_img_bit
);

  localparam int unsigned SUM_W = 10;  // 4 * 255 fits

  pix_t w_p11, w_p12, w_p13, w_p21, w_p22, w_p23, w_p31, w_p32, w_p33;
  logic w_tap_valid;
  logic w_border;

  line_matrix_3x3 #(
    .IMG_HDISP (IMG_HDISP)
  ) u_matrix (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_vsync     (per_frame_vsync),
    .i_href      (per_frame_href),
    .i_pix       (per_img_y),
    .o_p11       (w_p11),
    .o_p12       (w_p12),
    .o_p13       (w_p13),
    .o_p21       (w_p21),
    .o_p22       (w_p22),
    .o_p23       (w_p23),
    .o_p31       (w_p31),
    .o_p32       (w_p32),
    .o_p33       (w_p33),
    .o_tap_valid (w_tap_valid),
    .o_border    (w_border)
  );

  logic [LATENCY-1:0] r_vs_dly;
  logic [LATENCY-1:0] r_hr_dly;
  pix_t               r_thr;
  logic [SUM_W-1:0]   r_sx_pos, r_sx_neg, r_sy_pos, r_sy_neg;
  logic               r_v2;
  grad_t              r_gx, r_gy;
  logic               r_v3;
  pix_t               r_y;
  logic               r_bit;

  logic [SUM_W-1:0]  w_sx_pos, w_sx_neg, w_sy_pos, w_sy_neg;
  logic [GRAD_W-1:0] w_abs_gx, w_abs_gy;
  logic [MAG_W-1:0]  w_mag;
  pix_t              w_sat;
  logic              w_vs_rise;

  // r_vs_dly[0] is last cycle's vsync, so it doubles as the edge detector.
  assign w_vs_rise = per_frame_vsync & ~r_vs_dly[0];

  assign w_sx_pos = SUM_W'(w_p13) + SUM_W'({w_p23, 1'b0}) + SUM_W'(w_p33);
  assign w_sx_neg = SUM_W'(w_p11) + SUM_W'({w_p21, 1'b0}) + SUM_W'(w_p31);
  assign w_sy_pos = SUM_W'(w_p31) + SUM_W'({w_p32, 1'b0}) + SUM_W'(w_p33);
  assign w_sy_neg = SUM_W'(w_p11) + SUM_W'({w_p12, 1'b0}) + SUM_W'(w_p13);

  assign w_abs_gx = r_gx[GRAD_W-1] ? -r_gx : r_gx;
  assign w_abs_gy = r_gy[GRAD_W-1] ? -r_gy : r_gy;
  assign w_mag    = MAG_W'(w_abs_gx) + MAG_W'(w_abs_gy);
  assign w_sat    = (w_mag > MAG_W'(MAG_MAX)) ? pix_t'(MAG_MAX) : w_mag[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_dly <= '0;
      r_hr_dly <= '0;
      r_thr    <= '0;
      r_sx_pos <= '0;
      r_sx_neg <= '0;
      r_sy_pos <= '0;
      r_sy_neg <= '0;
      r_v2     <= 1'b0;
      r_gx     <= '0;
      r_gy     <= '0;
      r_v3     <= 1'b0;
      r_y      <= '0;
      r_bit    <= 1'b0;
    end else begin
      r_vs_dly <= {r_vs_dly[LATENCY-2:0], per_frame_vsync};
      r_hr_dly <= {r_hr_dly[LATENCY-2:0], per_frame_href};
      if (w_vs_rise) begin
        r_thr <= threshold;
      end
      // S2: weighted sums; border windows are dropped here.
      r_sx_pos <= w_sx_pos;
      r_sx_neg <= w_sx_neg;
      r_sy_pos <= w_sy_pos;
      r_sy_neg <= w_sy_neg;
      r_v2     <= w_tap_valid & ~w_border;
      // S3: gradients
      r_gx <= $signed({1'b0, r_sx_pos}) - $signed({1'b0, r_sx_neg});
      r_gy <= $signed({1'b0, r_sy_pos}) - $signed({1'b0, r_sy_neg});
      r_v3 <= r_v2;
      // S4: magnitude, saturate, compare
      r_y   <= r_v3 ? w_sat : '0;
      r_bit <= r_v3 && (w_sat > r_thr);
    end
  end

  assign pos_frame_vsync = r_vs_dly[LATENCY-1];
  assign pos_frame_href  = r_hr_dly[LATENCY-1];
  assign pos_img_y       = r_y;
  assign pos_img_bit     = r_bit;

endmodule
